// File: rtl/lsu_pkg.sv
// Shared LSU types, funct3 codes and byte-lane helpers.
// Misalign trapping is selected by LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsu_state_t;

  function automatic logic is_byte(
    input logic [2:0] f3
  );
    return (f3 == F3_B) || (f3 == F3_BU);
  endfunction

  function automatic logic is_half(
    input logic [2:0] f3
  );
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

  // Drops offset bits below the access size
  function automatic logic [1:0] eff_off(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    if (is_byte(f3)) return off;
    if (is_half(f3)) return {off[1], 1'b0};
    return 2'b00;
  endfunction

  function automatic logic [3:0] be_gen(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    if (is_byte(f3)) return 4'b0001 << off;
    if (is_half(f3))
      return off[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    if (is_byte(f3)) return {4{d[7:0]}};
    if (is_half(f3)) return {2{d[15:0]}};
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: lane shift plus sign/zero extension.
// Offset must already be reduced to the access size.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] sh;

  assign sh = word >> {offset, 3'b000};

  always_comb begin
    result = sh;
    unique case (1'b1)
      funct3 == F3_B:
        result = {{24{sh[7]}}, sh[7:0]};
      funct3 == F3_BU:
        result = {24'h0, sh[7:0]};
      funct3 == F3_H:
        result = {{16{sh[15]}}, sh[15:0]};
      funct3 == F3_HU:
        result = {16'h0, sh[15:0]};
      default:
        result = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_interface.sv
// LSU bridging core load/store requests to a valid/ready data bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu_mem_interface
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_t        state, state_nx;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mis_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ld_fmt;
  logic              mis;
  logic              accept;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = is_byte(req_funct3) ? 1'b0 :
               is_half(req_funct3) ? req_addr[0] :
               (req_addr[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid;

  lsu_load_align u_align (
    .word   (bus_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (ld_fmt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        off_q   <= eff_off(req_funct3, req_addr[1:0]);
        addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= store_data(req_funct3, req_wdata);
        mis_q   <= mis;
      end
      if (state == RESP && bus_rvalid) begin
        rdata_q <= ld_fmt;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (req_valid) state_nx = mis ? DONE : REQ;
      REQ:
        if (bus_ready) state_nx = we_q ? DONE : RESP;
      RESP:
        if (bus_rvalid) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_be    = 4'b0000;
    unique case (state)
      IDLE: stall = req_valid;
      REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        bus_we    = we_q;
        bus_be    = be_gen(f3_q, off_q);
      end
      RESP: stall = 1'b1;
      DONE: done  = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign misalign_err = (state == DONE) && mis_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Directed bench for lsu_mem_interface with a transaction-level model.
// Build with LSU_MISALIGN_TRAP_EN to exercise the trapping variant.
module tb_lsu_mem_interface;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misalign_err;
  logic [31:0] rdata;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_rvalid;

  always #5 clk = ~clk;

  lsu_mem_interface dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_done, e_valid, e_err, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;
  logic [31:0] m_rdata;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit is_b(input logic [2:0] f);
    return f == 3'b000 || f == 3'b100;
  endfunction

  function automatic bit is_h(input logic [2:0] f);
    return f == 3'b001 || f == 3'b101;
  endfunction

  function automatic bit misal(input logic [2:0] f,
                               input logic [31:0] a);
    if (!TRAP || is_b(f)) return 1'b0;
    if (is_h(f)) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic int lane(input logic [2:0] f,
                              input logic [31:0] a);
    if (is_b(f)) return int'(a[1:0]);
    if (is_h(f)) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f,
                                      input logic [31:0] a);
    if (is_b(f)) return 4'b0001 << lane(f, a);
    if (is_h(f)) return lane(f, a) == 2 ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f,
                                       input logic [31:0] d);
    if (is_b(f)) return {4{d[7:0]}};
    if (is_h(f)) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w,
                                         input logic [2:0] f,
                                         input logic [31:0] a);
    logic [31:0] v;
    v = w >> (8 * lane(f, a));
    case (f)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("bus_valid", {31'b0, bus_valid}, {31'b0, e_valid});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, e_err});
      chk("rdata", rdata, e_rdata);
      if (e_valid) begin
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", {28'b0, bus_be}, {28'b0, e_be});
        chk("bus_we", {31'b0, bus_we}, {31'b0, e_we});
        if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
      end
      if (bus_valid) begin
        cap_addr  = bus_addr;
        cap_be    = bus_be;
        cap_wdata = bus_wdata;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_set(input logic s, input logic d,
                         input logic v, input logic e);
    e_stall = s;
    e_done  = d;
    e_valid = v;
    e_err   = e;
    e_rdata = m_rdata;
  endtask

  task automatic access(input logic we, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int rw, input int vw,
                        input logic [31:0] word);
    bit mis;
    mis = misal(f, a);
    step();
    req_valid = 1'b1; req_we = we; req_funct3 = f;
    req_addr = a; req_wdata = wd;
    bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
    exp_set(1'b1, 1'b0, 1'b0, 1'b0);
    if (mis) begin
      step();
      req_valid = 1'b0;
      exp_set(1'b0, 1'b1, 1'b0, 1'b1);
      return;
    end
    e_addr  = {a[31:2], 2'b00};
    e_be    = m_be(f, a);
    e_we    = we;
    e_wdata = m_wd(f, wd);
    for (int i = 0; i <= rw; i++) begin
      step();
      req_valid = (i == 0) ? 1'b0 : 1'b1;
      req_addr  = 32'hFFFF_FFF3;
      req_we    = ~we;
      bus_ready = (i == rw);
      exp_set(1'b1, 1'b0, 1'b1, 1'b0);
    end
    if (!we) begin
      for (int j = 0; j <= vw; j++) begin
        step();
        req_valid  = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = (j == vw);
        bus_rdata  = (j == vw) ? word : ~word;
        exp_set(1'b1, 1'b0, 1'b0, 1'b0);
      end
      m_rdata = m_load(word, f, a);
    end
    step();
    req_valid = 1'b0; bus_ready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h5555AAAA;
    exp_set(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    m_rdata = 32'h0;
    cap_addr = 32'h0; cap_be = 4'h0; cap_wdata = 32'h0;
    e_addr = 32'h0; e_be = 4'h0; e_we = 1'b0; e_wdata = 32'h0;
    exp_set(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
    step();
    rst_n = 1'b1;

    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    chk("t1_be", {28'b0, cap_be}, 32'hF);
    chk("t1_addr", cap_addr, 32'h100);
    chk("t1_wdata", cap_wdata, 32'hDEADBEEF);

    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
    chk("t2_lb", rdata, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000);
    chk("t2_lbu", rdata, 32'h00000080);

    access(1'b0, 3'b001, 32'h102, 32'h0, 3, 2, 32'h80011234);
    chk("t3_lh", rdata, 32'hFFFF8001);

    access(1'b1, 3'b000, 32'h101, 32'h0000005A, 1, 0, 32'h0);
    chk("t4_be", {28'b0, cap_be}, 32'h2);
    chk("t4_wdata", cap_wdata, 32'h5A5A5A5A);

    access(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t5_rdata_held", rdata, 32'hFFFF8001);
`else
    chk("t5_addr", cap_addr, 32'h100);
    chk("t5_be", {28'b0, cap_be}, 32'hF);
    chk("t5_rdata", rdata, 32'hCAFEF00D);
`endif

    access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'h0);
    access(1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80011234);
    chk("lhu", rdata, 32'h00008001);
    access(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0000F00F);
    access(1'b0, 3'b011, 32'h104, 32'h0, 0, 0, 32'h87654321);
    access(1'b1, 3'b000, 32'h103, 32'hFFFFFFC3, 2, 0, 32'h0);
    access(1'b1, 3'b110, 32'h108, 32'h0BADCAFE, 0, 0, 32'h0);
    access(1'b0, 3'b001, 32'h100, 32'h0, 0, 0, 32'h00017FFE);

    step();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h300; bus_ready = 1'b0; bus_rvalid = 1'b0;
    exp_set(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    req_valid = 1'b0; bus_ready = 1'b1;
    e_addr = 32'h300; e_be = 4'hF; e_we = 1'b0;
    exp_set(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    bus_ready = 1'b0; rst_n = 1'b0;
    exp_set(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    m_rdata = 32'h0;
    exp_set(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    bus_rvalid = 1'b0;
    exp_set(1'b0, 1'b0, 1'b0, 1'b0);

    access(1'b0, 3'b010, 32'h200, 32'h0, 1, 1, 32'h12345678);
    chk("post_rst_lw", rdata, 32'h12345678);

    step();
    exp_set(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
